// File: rtl/tri_sequencer.sv
// Triangle sequencer: accepts a primitive of one or two triangles, then presents
// the triangles one at a time to the rasterizer. Zero-area triangles can be
// dropped and counted instead of emitted.
module tri_sequencer #(
  parameter bit SKIP_DEGEN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_quad,
  input  logic [15:0] x0_0,
  input  logic [15:0] y0_0,
  input  logic [15:0] x1_0,
  input  logic [15:0] y1_0,
  input  logic [15:0] x2_0,
  input  logic [15:0] y2_0,
  input  logic [15:0] x0_1,
  input  logic [15:0] y0_1,
  input  logic [15:0] x1_1,
  input  logic [15:0] y1_1,
  input  logic [15:0] x2_1,
  input  logic [15:0] y2_1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x0,
  output logic [15:0] out_y0,
  output logic [15:0] out_x1,
  output logic [15:0] out_y1,
  output logic [15:0] out_x2,
  output logic [15:0] out_y2,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {StIdle, StT0, StT1} state_e;

  // Triangle packing: [0]=x0 [1]=y0 [2]=x1 [3]=y1 [4]=x2 [5]=y2
  typedef logic [5:0][15:0] tri_t;

  state_e      state_q, state_d;
  tri_t        tri0_q, tri1_q;
  logic        quad_q;
  logic [7:0]  drop_cnt_q;

  tri_t        out_tri;
  logic        degen0, degen1;
  logic        drop;
  logic        drop_inc;
  logic        emit;
  logic        accept;

  // Twice the signed area; 17-bit differences and 34-bit products cannot overflow.
  function automatic logic [34:0] area2(input tri_t t);
    logic [16:0] dx1, dy1, dx2, dy2;
    logic [33:0] p0, p1;
    dx1 = {t[2][15], t[2]} - {t[0][15], t[0]};
    dy2 = {t[5][15], t[5]} - {t[1][15], t[1]};
    dx2 = {t[4][15], t[4]} - {t[0][15], t[0]};
    dy1 = {t[3][15], t[3]} - {t[1][15], t[1]};
    // Low 34 bits of an unsigned product of sign-extended operands equal the signed product.
    p0 = {{17{dx1[16]}}, dx1} * {{17{dy2[16]}}, dy2};
    p1 = {{17{dx2[16]}}, dx2} * {{17{dy1[16]}}, dy1};
    return {p0[33], p0} - {p1[33], p1};
  endfunction

  assign degen0 = (area2(tri0_q) == 35'd0);
  assign degen1 = (area2(tri1_q) == 35'd0);

  // Output decode: presented triangle, valid/last flags and drop pulses per state.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_tri   = '0;
    drop      = 1'b0;
    unique case (state_q)
      StT0: begin
        if (SKIP_DEGEN && degen0) begin
          drop = 1'b1;
        end else begin
          out_valid = 1'b1;
          out_tri   = tri0_q;
          out_last  = !quad_q || (SKIP_DEGEN && degen1);
        end
      end
      StT1: begin
        if (SKIP_DEGEN && degen1) begin
          drop = 1'b1;
        end else begin
          out_valid = 1'b1;
          out_tri   = tri1_q;
          out_last  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign emit     = out_valid && out_ready;
  assign in_ready = (state_q == StIdle) || (emit && out_last);
  assign accept   = in_valid && in_ready;
  // A degenerate second triangle of a quad is skipped at the first emit, never visited.
  assign drop_inc = drop ||
                    ((state_q == StT0) && emit && quad_q && SKIP_DEGEN && degen1);

  assign out_x0   = out_tri[0];
  assign out_y0   = out_tri[1];
  assign out_x1   = out_tri[2];
  assign out_y1   = out_tri[3];
  assign out_x2   = out_tri[4];
  assign out_y2   = out_tri[5];
  assign busy     = (state_q != StIdle);
  assign drop_cnt = drop_cnt_q;

  // Next-state: a last emit may overlap a fresh accept for zero-bubble streaming.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StT0;
      StT0: begin
        if (drop) begin
          state_d = quad_q ? StT1 : StIdle;
        end else if (emit) begin
          if (!out_last)   state_d = StT1;
          else if (accept) state_d = StT0;
          else             state_d = StIdle;
        end
      end
      StT1: begin
        if (drop)      state_d = StIdle;
        else if (emit) state_d = accept ? StT0 : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Holding registers, loaded only on accept so outputs stay stable under backpressure.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tri0_q <= '0;
      tri1_q <= '0;
      quad_q <= 1'b0;
    end else if (accept) begin
      tri0_q <= {y2_0, x2_0, y1_0, x1_0, y0_0, x0_0};
      tri1_q <= {y2_1, x2_1, y1_1, x1_1, y0_1, x0_1};
      quad_q <= in_quad;
    end
  end

  // Saturating count of dropped triangles.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                            drop_cnt_q <= 8'd0;
    else if (drop_inc && drop_cnt_q != 8'hff) drop_cnt_q <= drop_cnt_q + 8'd1;
  end

endmodule

// File: tb/tb_tri_sequencer.sv
// Self-checking bench for tri_sequencer: table of single primitives plus
// hand-written backpressure, streaming, saturation and reset sequences.
module tb_tri_sequencer;

  typedef logic [5:0][15:0] tri_t;

  typedef struct {
    string       name;
    logic        quad;
    tri_t        t0;
    tri_t        t1;
    int          emits;
    int          drops;
    logic [15:0] first_x1;
    logic        first_last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_quad = 1'b0;
  logic [15:0] x0_0 = '0, y0_0 = '0, x1_0 = '0, y1_0 = '0, x2_0 = '0, y2_0 = '0;
  logic [15:0] x0_1 = '0, y0_1 = '0, x1_1 = '0, y1_1 = '0, x2_1 = '0, y2_1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_x0, out_y0, out_x1, out_y1, out_x2, out_y2;
  logic        out_last;
  logic        busy;
  logic [7:0]  drop_cnt;

  int passed = 0;
  int total  = 0;
  int exp_drops = 0;

  always #5 clk = ~clk;

  tri_sequencer #(.SKIP_DEGEN(1'b1)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_quad   (in_quad),
    .x0_0      (x0_0), .y0_0 (y0_0), .x1_0 (x1_0), .y1_0 (y1_0), .x2_0 (x2_0), .y2_0 (y2_0),
    .x0_1      (x0_1), .y0_1 (y0_1), .x1_1 (x1_1), .y1_1 (y1_1), .x2_1 (x2_1), .y2_1 (y2_1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x0    (out_x0), .out_y0 (out_y0), .out_x1 (out_x1),
    .out_y1    (out_y1), .out_x2 (out_x2), .out_y2 (out_y2),
    .out_last  (out_last),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  function automatic tri_t tri6(input int ax0, input int ay0, input int ax1, input int ay1,
                                input int ax2, input int ay2);
    tri_t t;
    t[0] = 16'(ax0); t[1] = 16'(ay0); t[2] = 16'(ax1);
    t[3] = 16'(ay1); t[4] = 16'(ax2); t[5] = 16'(ay2);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic drive_prim(input logic q, input tri_t a, input tri_t b);
    in_quad = q;
    x0_0 = a[0]; y0_0 = a[1]; x1_0 = a[2]; y1_0 = a[3]; x2_0 = a[4]; y2_0 = a[5];
    x0_1 = b[0]; y0_1 = b[1]; x1_1 = b[2]; y1_1 = b[3]; x2_1 = b[4]; y2_1 = b[5];
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Offer one primitive from idle with out_ready high and observe five cycles.
  task automatic run_vec(input vec_t v);
    int          emits;
    logic [15:0] fx1;
    logic        fl;
    logic        ll;
    emits = 0; fx1 = '0; fl = 1'b0; ll = 1'b0;
    @(negedge clk);
    drive_prim(v.quad, v.t0, v.t1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({v.name, " in_ready idle"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (out_valid && out_ready) begin
        if (emits == 0) begin
          fx1 = out_x1;
          fl  = out_last;
        end
        ll = out_last;
        emits++;
      end
      @(negedge clk);
    end
    exp_drops = sat255(exp_drops + v.drops);
    check({v.name, " emits"}, 32'(emits), 32'(v.emits));
    check({v.name, " drop_cnt"}, 32'(drop_cnt), 32'(exp_drops));
    if (v.emits > 0) begin
      check({v.name, " first x1"}, 32'(fx1), 32'(v.first_x1));
      check({v.name, " first last"}, 32'(fl), 32'(v.first_last));
      check({v.name, " final last"}, 32'(ll), 32'd1);
    end
    check({v.name, " busy after"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int   first_c, last_c, emits, accepts;
    logic seen;

    vecs[0] = '{"quad", 1'b1, tri6(0,0,10,0,0,10), tri6(10,0,10,10,0,10), 2, 0, 16'd10, 1'b0};
    vecs[1] = '{"single", 1'b0, tri6(0,0,5,0,0,5), tri6(0,0,1,0,0,1), 1, 0, 16'd5, 1'b1};
    vecs[2] = '{"degen t0", 1'b1, tri6(0,0,4,4,8,8), tri6(1,0,7,0,0,3), 1, 1, 16'd7, 1'b1};
    vecs[3] = '{"degen t1", 1'b1, tri6(0,0,3,0,0,3), tri6(1,1,2,2,3,3), 1, 1, 16'd3, 1'b1};
    vecs[4] = '{"both degen", 1'b1, tri6(0,0,0,0,0,0), tri6(5,5,6,6,7,7), 0, 2, 16'd0, 1'b0};
    vecs[5] = '{"single degen", 1'b0, tri6(1,2,1,2,9,9), tri6(0,0,1,0,0,1), 0, 1, 16'd0, 1'b0};
    vecs[6] = '{"extremes", 1'b1, tri6(-32768,-32768,32767,-32768,-32768,32767),
                tri6(32767,32767,-32768,32767,32767,-32768), 2, 0, 16'h7fff, 1'b0};
    vecs[7] = '{"area 65536", 1'b0, tri6(0,0,256,0,0,256), tri6(0,0,0,0,0,0), 1, 0,
                16'd256, 1'b1};

    // Reset state
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset drop_cnt", 32'(drop_cnt), 32'd0);
    check("reset out_x1", 32'(out_x1), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: out_ready low for five cycles in T0
    @(negedge clk);
    drive_prim(1'b1, tri6(0,0,10,0,0,10), tri6(10,0,10,10,0,10));
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    drive_prim(1'b0, tri6(0,0,0,0,0,0), tri6(0,0,0,0,0,0));
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_x1 stable", 32'(out_x1), 32'd10);
      check("bp out_y2 stable", 32'(out_y2), 32'd10);
      check("bp in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp t0 emit valid", 32'(out_valid), 32'd1);
    check("bp t0 last", 32'(out_last), 32'd0);
    check("bp t0 in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    check("bp t1 x0", 32'(out_x0), 32'd10);
    check("bp t1 last", 32'(out_last), 32'd1);
    check("bp t1 in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1;
    check("bp idle busy", 32'(busy), 32'd0);
    check("bp idle out_x0", 32'(out_x0), 32'd0);

    // Streaming: three quads back-to-back
    accepts = 0; emits = 0; first_c = -1; last_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (accepts < 3);
      if (accepts < 3) drive_prim(1'b1, tri6(0,0,20+accepts,0,0,10), tri6(10,0,10,10,0,10));
      #1;
      if (out_valid && out_ready) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        if (emits % 2 == 0) check("stream t0 x1", 32'(out_x1), 32'(20 + emits / 2));
        else                check("stream t1 last", 32'(out_last), 32'd1);
        emits++;
      end
      if (in_valid && in_ready) accepts++;
    end
    check("stream emits", 32'(emits), 32'd6);
    check("stream first cycle", 32'(first_c), 32'd1);
    check("stream span", 32'(last_c - first_c), 32'd5);

    // Saturation: many dropped single triangles, never a valid pulse
    seen = 1'b0;
    repeat (260) begin
      @(negedge clk);
      drive_prim(1'b0, tri6(0,0,0,0,0,0), tri6(0,0,0,0,0,0));
      in_valid = 1'b1;
      #1;
      if (out_valid) seen = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) seen = 1'b1;
    end
    exp_drops = sat255(exp_drops + 260);
    check("sat no out_valid", 32'(seen), 32'd0);
    check("sat drop_cnt", 32'(drop_cnt), 32'(exp_drops));

    // Reset asserted while in T1
    @(negedge clk);
    drive_prim(1'b1, tri6(0,0,10,0,0,10), tri6(10,0,10,10,0,10));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("t1 before reset valid", 32'(out_valid), 32'd1);
    rst_b = 1'b0;
    #1;
    exp_drops = 0;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset out_x1", 32'(out_x1), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("post reset no valid", 32'(seen), 32'd0);
    check("post reset in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tri_sequencer.md
TRI_SEQUENCER -- requirements
Module: tri_sequencer

Interface
REQ-001 SKIP_DEGEN, default 1: when 1, zero-area triangles are dropped rather than emitted.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst_b  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  a primitive (one or two triangles) is presented.
REQ-005 in_ready  out  1  the sequencer can accept a primitive this cycle.
REQ-006 in_quad  in  1  1 = both triangles valid; 0 = only triangle 0 valid.
REQ-007 x0_0,y0_0,x1_0,y1_0,x2_0,y2_0  in  16 each  triangle 0 vertices, signed.
REQ-008 x0_1,y0_1,x1_1,y1_1,x2_1,y2_1  in  16 each  triangle 1 vertices, signed.
REQ-009 out_valid  out  1  a triangle is presented to the rasterizer.
REQ-010 out_ready  in  1  the rasterizer accepts the presented triangle.
REQ-011 out_x0,out_y0,out_x1,out_y1,out_x2,out_y2  out  16 each  presented triangle vertices.
REQ-012 out_last  out  1  the presented triangle is the final one emitted for its primitive.
REQ-013 busy  out  1  the state is not IDLE.
REQ-014 drop_cnt  out  8  count of dropped degenerate triangles, saturating at 255.

Function
REQ-015 The FSM SHALL have three states: IDLE, T0 and T1.
REQ-016 An accept SHALL occur when in_valid and in_ready are both high; an emit SHALL occur when out_valid and out_ready are both high.
REQ-017 On accept, the sequencer SHALL capture all 12 coordinates and in_quad into holding registers and enter T0.
REQ-018 The output ports SHALL be driven only from the holding registers, so that they stay stable while out_valid is high and out_ready is low.
REQ-019 For each held triangle, the sequencer SHALL compute area2 = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0) at full width: 17-bit sign-extended differences, 34-bit products, 35-bit signed result; the triangle is degenerate when area2 equals 0.
REQ-020 The sequencer SHALL assume no winding order; any nonzero area2 is emitted with vertex order unchanged.
REQ-021 T0, triangle 0 non-degenerate or SKIP_DEGEN=0: out_valid=1, outputs = triangle 0, out_last = !quad | (SKIP_DEGEN & degen1); on emit go to T1 if !out_last, else to IDLE.
REQ-022 T0, triangle 0 degenerate and SKIP_DEGEN=1: out_valid=0 for one cycle, drop_cnt increments, then go to T1 if quad, else to IDLE.
REQ-023 T1, triangle 1 non-degenerate or SKIP_DEGEN=0: out_valid=1, outputs = triangle 1, out_last=1; on emit go to IDLE.
REQ-024 T1, triangle 1 degenerate and SKIP_DEGEN=1: out_valid=0 for one cycle, drop_cnt increments, go to IDLE.
REQ-025 A quad whose triangle 1 is degenerate SHALL never enter T1; drop_cnt increments by 1 at the T0 emit.
REQ-026 in_ready = (state==IDLE) | (emit & out_last), so back-to-back primitives stream with zero bubble.
REQ-027 When an accept coincides with a last emit, the new primitive SHALL be captured and the FSM SHALL go to T0; the in-flight triangle completes normally.
REQ-028 No out_valid pulse SHALL occur for a primitive whose triangles are all dropped.
REQ-029 drop_cnt SHALL hold at 255 with no wrap.
REQ-030 Outputs SHALL be 0 and out_valid SHALL be 0 in IDLE.
REQ-031 out_valid SHALL not deassert once asserted until an emit occurs.

Reset
REQ-032 While rst_b is low: state=IDLE, holding registers=0, drop_cnt=0, out_valid=0, out_last=0, busy=0, outputs=0, in_ready=1 on release.
REQ-033 Reset asserted mid-primitive SHALL discard the held primitive with no further out_valid.

Verification
REQ-034 Quad: T0=(0,0),(10,0),(0,10), T1=(10,0),(10,10),(0,10), out_ready=1 -> two consecutive emits, out_last=0 then 1, in_ready high in the second emit cycle.
REQ-035 Triangle: in_quad=0, T0=(0,0),(5,0),(0,5) -> one emit, out_last=1, returns to IDLE next cycle.
REQ-036 Degenerate T0=(0,0),(4,4),(8,8) with a valid T1, SKIP_DEGEN=1 -> one idle cycle, drop_cnt=1, T1 emitted with out_last=1.
REQ-037 Backpressure: out_ready low for 5 cycles in T0 -> out_valid stays high, outputs constant, in_ready=0, then emits proceed.
REQ-038 Streaming: 3 quads offered back-to-back with out_ready=1 -> 6 emits in 6 consecutive cycles after the first accept.
REQ-039 Coordinates at extremes (-32768, 32767) -> area2 computed without overflow; rst_b pulsed in T1 -> out_valid=0 immediately and drop_cnt=0.
